// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multiply/divide unit with architectural HI/LO registers for the MIPS execute stage.
// Define HILO_FAST_MUL_EN for a single-cycle multiplier; division is always iterative.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [2:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;

  // Operand decode: signed ops work on magnitudes, signs re-applied in FIX
  logic             is_signed, sa, sb, iter_op;
  logic [WIDTH-1:0] a_abs, b_abs;
  always_comb begin
    is_signed = (opE == OP_MULT) || (opE == OP_DIV);
    sa        = is_signed & srcaE[WIDTH-1];
    sb        = is_signed & srcbE[WIDTH-1];
    a_abs     = sa ? -srcaE : srcaE;
    b_abs     = sb ? -srcbE : srcbE;
`ifdef HILO_FAST_MUL_EN
    iter_op   = (opE == OP_DIV) || (opE == OP_DIVU);
`else
    iter_op   = (opE == OP_DIV) || (opE == OP_DIVU) || (opE == OP_MULT) || (opE == OP_MULTU);
`endif
  end

  // acc holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_diff, q_fix, r_fix;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, opb_q};
    div_diff = div_sh[WIDTH-1:0] - opb_q;
    prod_fix = negq_q ? -acc_q : acc_q;
    q_fix    = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    r_fix    = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

`ifdef HILO_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  logic               fdone_q, fdone_d;
  // Low 2*WIDTH bits of the extended product are correct for both signednesses
  always_comb
    fast_prod = {{WIDTH{sa}}, srcaE} * {{WIDTH{sb}}, srcbE};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
`ifdef HILO_FAST_MUL_EN
    fdone_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        busy = startE & ~cancel & iter_op;
        if (startE && !cancel) begin
          case (opE)
            OP_MTHI: hi_d = srcaE;
            OP_MTLO: lo_d = srcaE;
            OP_MULT, OP_MULTU: begin
`ifdef HILO_FAST_MUL_EN
              {hi_d, lo_d} = fast_prod;
              fdone_d      = 1'b1;
`else
              state_d  = S_MUL;
              acc_d    = {{WIDTH{1'b0}}, b_abs};
              opb_d    = a_abs;
              negq_d   = sa ^ sb;
              negr_d   = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = CW'(WIDTH-1);
`endif
            end
            OP_DIV, OP_DIVU: begin
              state_d  = S_DIV;
              acc_d    = {{WIDTH{1'b0}}, a_abs};
              opb_d    = b_abs;
              // x/0 leaves an all-ones quotient that must not be negated
              negq_d   = (sa ^ sb) & (srcbE != '0);
              negr_d   = sa;
              is_div_d = 1'b1;
              cnt_d    = CW'(WIDTH-1);
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_DIV: begin
        acc_d = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIX: begin
        done    = 1'b1;
        state_d = S_IDLE;
        if (is_div_q) begin
          hi_d = r_fix;
          lo_d = q_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (cancel && state_q != S_IDLE) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done    = 1'b0;
    end
`ifdef HILO_FAST_MUL_EN
    done = done | fdone_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

`ifdef HILO_FAST_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fdone_q <= 1'b0;
    else     fdone_q <= fdone_d;
  end
`endif

  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: an arithmetic reference model checked every cycle plus literal checks.
module tb_hilo_muldiv;
  localparam int W = 32;
`ifdef HILO_FAST_MUL_EN
  localparam int MUL_BUSY = 0;
  localparam int MUL_DONE = 1;
`else
  localparam int MUL_BUSY = W + 2;
  localparam int MUL_DONE = W + 1;
`endif

  logic         clk = 1'b0, rst = 1'b1, startE = 1'b0, cancel = 1'b0;
  logic [2:0]   opE = 3'b000;
  logic [W-1:0] srcaE = '0, srcbE = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done;
  int           nchk = 0, nerr = 0;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .startE(startE), .opE(opE), .srcaE(srcaE), .srcbE(srcbE),
    .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}
  function automatic logic [2*W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa_l, sb_l;
    logic [2*W-1:0] r;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    r = '0;
    case (op)
      3'b001: r = sa_l * sb_l;
      3'b010: r = {32'b0, a} * {32'b0, b};
      3'b011: if (b == '0) r = {a, {W{1'b1}}};
              else begin r[W-1:0] = W'(sa_l / sb_l); r[2*W-1:W] = W'(sa_l % sb_l); end
      3'b100: if (b == '0) r = {a, {W{1'b1}}};
              else r = {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic bit is_iter(input logic [2:0] op);
`ifdef HILO_FAST_MUL_EN
    return op == 3'b011 || op == 3'b100;
`else
    return op == 3'b001 || op == 3'b010 || op == 3'b011 || op == 3'b100;
`endif
  endfunction

  // Model: rem = cycles still to spend after the accept cycle; result commits when it reaches 1
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int           m_rem = 0;
  logic         m_fdone = 1'b0;
  bit           run = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_fdone = 1'b0;
    end else begin
      m_fdone = 1'b0;
      if (m_rem > 0) begin
        if (cancel) m_rem = 0;
        else begin
          if (m_rem == 1) begin m_hi = p_hi; m_lo = p_lo; end
          m_rem--;
        end
      end else if (startE && !cancel) begin
        case (opE)
          3'b101: m_hi = srcaE;
          3'b110: m_lo = srcaE;
          3'b001, 3'b010, 3'b011, 3'b100: begin
            {p_hi, p_lo} = ref_result(opE, srcaE, srcbE);
            if (is_iter(opE)) m_rem = W + 1;
            else begin m_hi = p_hi; m_lo = p_lo; m_fdone = 1'b1; end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
      chk("cyc_busy", W'(busy), W'(m_rem > 0 || (startE && !cancel && is_iter(opE))));
      chk("cyc_done", W'(done), W'((m_rem == 1 && !cancel) || m_fdone));
    end
  end

  // Issue one op in the current cycle; count busy cycles and note the done cycle
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int nb, output int dc);
    bit fin;
    fin = 1'b0; nb = 0; dc = -1;
    startE = 1'b1; opE = op; srcaE = a; srcbE = b;
    for (int c = 0; c < 60 && !fin; c++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) dc = c;
      if (c > 0 && !busy) fin = 1'b1;
      else begin @(posedge clk); #1; startE = 1'b0; end
    end
    chk("issue_timeout", W'(fin), W'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    int   nb, dc;
    logic sawdone;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    run = 1'b1;

    issue(3'b100, 32'd100, 32'd7, nb, dc);
    chk("divu_busy_len", W'(nb), 32'd34);
    chk("divu_done_cyc", W'(dc), 32'd33);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    issue(3'b011, 32'hFFFFFFF9, 32'd2, nb, dc);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);
    issue(3'b011, 32'h80000000, 32'hFFFFFFFF, nb, dc);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'h0);

    issue(3'b100, 32'd5, 32'd0, nb, dc);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'd5);
    chk("divu0_busy_len", W'(nb), 32'd34);
    chk("divu0_done_cyc", W'(dc), 32'd33);
    issue(3'b011, 32'hFFFFFFFB, 32'd0, nb, dc);
    chk("div0_lo", lo, 32'hFFFFFFFF);
    chk("div0_hi", hi, 32'hFFFFFFFB);
    chk("div0_busy_len", W'(nb), 32'd34);

    issue(3'b001, 32'hFFFFFFFE, 32'd3, nb, dc);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    chk("mult_busy_len", W'(nb), W'(MUL_BUSY));
    chk("mult_done_cyc", W'(dc), W'(MUL_DONE));
    issue(3'b010, 32'hFFFFFFFE, 32'd3, nb, dc);
    chk("multu_hi", hi, 32'd2);
    chk("multu_lo", lo, 32'hFFFFFFFA);
    chk("multu_busy_len", W'(nb), W'(MUL_BUSY));
    issue(3'b001, 32'h80000000, 32'h80000000, nb, dc);
    chk("mult_min_hi", hi, 32'h40000000);
    chk("mult_min_lo", lo, 32'h0);

    issue(3'b101, 32'h1234, 32'd0, nb, dc);
    chk("mthi_busy_len", W'(nb), '0);
    issue(3'b110, 32'h5678, 32'd0, nb, dc);
    chk("mthi_hi", hi, 32'h1234);
    chk("mtlo_lo", lo, 32'h5678);

    // Cancel a DIVU in its cycle 10
    sawdone = 1'b0;
    startE = 1'b1; opE = 3'b100; srcaE = 32'd1000; srcbE = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); if (done) sawdone = 1'b1;
      @(posedge clk); #1; startE = 1'b0;
    end
    cancel = 1'b1;
    @(negedge clk);
    if (done) sawdone = 1'b1;
    chk("cancel_busy_c10", W'(busy), 32'd1);
    @(posedge clk); #1; cancel = 1'b0;
    @(negedge clk);
    chk("cancel_idle", W'(busy), '0);
    chk("cancel_hi", hi, 32'h1234);
    chk("cancel_lo", lo, 32'h5678);
    chk("cancel_nodone", W'(sawdone | done), '0);
    repeat (36) @(posedge clk);
    #1;
    chk("cancel_hi_late", hi, 32'h1234);

    // Asynchronous reset in cycle 5 of a DIV
    startE = 1'b1; opE = 3'b011; srcaE = 32'd77; srcbE = 32'd5;
    @(posedge clk); #1; startE = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", W'(busy), '0);
    chk("arst_done", W'(done), '0);
    chk("arst_hi", hi, '0);
    chk("arst_lo", lo, '0);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    issue(3'b100, 32'd9, 32'd3, nb, dc);
    chk("post_rst_lo", lo, 32'd3);
    chk("post_rst_hi", hi, 32'd0);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
